ct_wrr_sched: RTL and testbench
===============================

Name: ct_wrr_sched

Overview:
Weighted round-robin packet scheduler that drives the select, valid, ready and eop of an NI-input packet merge datapath. It grants one input for a "turn" of up to quantum[i] whole packets before rotating. Packets are never interleaved. Per-input quantum and enable are runtime-configurable through a simple write port. It sits in front of the merge mux; the data mux itself stays external and is driven by o_sel.

Parameters:
NI, 4, number of requesting inputs (>=1)
QBITS, 4, width of per-input quantum (packets per turn)
NIBITS, max(1, clog2(NI)), select width (derived localparam, not overridable)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_valid  in  NI  per-input beat valid
i_eop  in  NI  per-input end-of-packet, qualified by i_valid
o_ready  out  NI  per-input ready
i_ready  in  1  downstream ready
o_valid  out  1  merged output valid
o_eop  out  1  merged output eop
o_sel  out  NIBITS  select for the external data mux
cfg_wr  in  1  config write strobe
cfg_idx  in  NIBITS  input being configured (writes with cfg_idx>=NI are ignored)
cfg_quantum  in  QBITS  packets per turn; 0 is treated as 1
cfg_enable  in  1  input may win arbitration

Behaviour:
- Beat accepted when o_valid && i_ready.
- Combinational outputs:
  - o_valid = i_valid[o_sel]
  - o_eop = i_eop[o_sel]
  - o_ready[i] = i_ready && (i==o_sel) && state-permits
  - Zero-latency flow-through, no bubble on grant.
- Eligibility: elig[i] = i_valid[i] && en[i].
- RR pick: first eligible input scanning last+1, last+2, ..., last (wraps). If none eligible, pick = last, and o_valid then reflects i_valid[last].
- Registers:
  - state
  - cur (granted input)
  - last (previous turn owner)
  - cnt (packets remaining in turn after the current one, QBITS wide)
  - q[NI]
  - en[NI]
- Reset values (reset low):
  - state=S_ARB, last=NI-1 (input 0 wins first), cur=0, cnt=0, q[i]=1, en[i]=1
  - Outputs while reset is asserted: o_valid=0, o_ready=0, o_eop=0, o_sel=0.
- State S_ARB: o_sel=pick. On an accepted beat:
  - cur<=pick, last<=pick, cnt<=max(q[pick],1)-1.
  - If !eop, go to S_PKT.
  - Else if the new cnt>0, go to S_TURN.
  - Else stay in S_ARB.
- State S_PKT (mid-packet lock): o_sel=cur; en is ignored so the packet always completes. On an accepted eop beat:
  - cnt==0: go to S_ARB.
  - Otherwise: go to S_TURN.
  - Non-eop beats keep S_PKT.
- State S_TURN (between packets of one turn):
  - If elig[cur]: o_sel=cur. On an accepted beat, cnt<=cnt-1. Then: !eop goes to S_PKT; eop with cnt-1==0 goes to S_ARB; otherwise stay in S_TURN.
  - If !elig[cur]: the turn is forfeited in the same cycle. Behave exactly as S_ARB: o_sel=pick, same update rules, no idle cycle. If nothing is accepted, next state is S_ARB and cnt<=0.
- Config:
  - On cfg_wr, q[cfg_idx]<=cfg_quantum and en[cfg_idx]<=cfg_enable at the clock edge.
  - The new quantum takes effect from the next turn start; cnt of a turn in progress is not modified.
  - Disabling the current owner mid-packet lets the packet finish; the turn is then forfeited at S_TURN.
- Simultaneous events:
  - A config write to the input being picked in the same cycle: the turn start uses the old q.
  - A single-beat packet (eop on first beat) never enters S_PKT.
- i_ready low: no state change; o_sel is held stable in S_PKT/S_TURN.
- NI=1: o_sel is always 0; quantum is irrelevant apart from counting.
- Reset asserted mid-packet: everything returns to reset values at once; the partial packet is abandoned, and recovery belongs to the upstream logic.

Test Plan:
- Reset, then all 4 inputs continuously valid with 1-beat packets, q=1, i_ready=1 -> grants 0,1,2,3,0,... one per cycle, no bubbles.
- q[0]=3, others 1, all inputs sending 2-beat packets -> 3 packets (6 beats) from input 0, then 2 beats from 1, 2 beats from 2, 2 beats from 3, repeating. Beats of different packets are never interleaved.
- Input 1 sends a 4-beat packet with i_valid gapped and i_ready toggling -> o_sel stays 1 through the packet, and no other o_ready rises until the eop beat is accepted.
- q[2]=4, input 2 drops valid after its first packet while input 3 is valid -> in that same cycle o_sel=3 and input 3 is accepted. No idle cycle.
- cfg_wr disabling input 1 during its packet -> packet completes, its turn ends, and input 1 is never picked again until re-enabled.
- Reset deasserted then reasserted during S_PKT -> o_valid/o_ready are 0 immediately. After release, input 0 is granted first and cnt=0.

Source files
------------

// File: rtl/ct_wrr_sched.sv
// Weighted round-robin packet scheduler for an NI-input merge: grants whole packets,
// up to quantum[i] packets per turn, and steers an external data mux through o_sel.
module ct_wrr_sched #(
  parameter  int NI     = 4,
  parameter  int QBITS  = 4,
  localparam int NIBITS = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NI-1:0]     i_valid,
  input  logic [NI-1:0]     i_eop,
  output logic [NI-1:0]     o_ready,
  input  logic              i_ready,
  output logic              o_valid,
  output logic              o_eop,
  output logic [NIBITS-1:0] o_sel,
  input  logic              cfg_wr,
  input  logic [NIBITS-1:0] cfg_idx,
  input  logic [QBITS-1:0]  cfg_quantum,
  input  logic              cfg_enable
);

  typedef enum logic [1:0] {S_ARB, S_PKT, S_TURN} state_t;

  state_t            state_q, state_d;
  logic [NIBITS-1:0] cur_q, cur_d;
  logic [NIBITS-1:0] last_q, last_d;
  logic [QBITS-1:0]  cnt_q, cnt_d;
  logic [QBITS-1:0]  q_q [NI];
  logic [NI-1:0]     en_q;

  logic [NI-1:0]     elig;
  logic [NIBITS-1:0] pick;
  logic [NIBITS-1:0] sel;
  logic [QBITS-1:0]  q_pick;
  logic [QBITS-1:0]  q_start;
  logic              arb_mode;
  logic              permit;
  logic              acc;
  logic              beat_eop;
  logic              found;
  int                idx;

  assign elig = i_valid & en_q;

  // Round-robin scan starting just after the previous turn owner.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NI; k++) begin
      idx = (int'(last_q) + k) % NI;
      if (!found && elig[idx]) begin
        pick  = NIBITS'(idx);
        found = 1'b1;
      end
    end
  end

  assign q_pick  = q_q[pick];
  assign q_start = (q_pick == '0) ? '0 : q_pick - QBITS'(1);

  // A turn whose owner has gone idle is forfeited in the same cycle, so S_TURN
  // falls back to arbitration without an idle cycle.
  assign arb_mode = (state_q == S_ARB) || ((state_q == S_TURN) && !elig[cur_q]);
  assign sel      = arb_mode ? pick : cur_q;
  assign permit   = arb_mode ? elig[sel] : 1'b1;
  assign beat_eop = i_eop[sel];
  assign acc      = reset && i_ready && permit && i_valid[sel];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_ARB;
      cur_q   <= '0;
      last_q  <= NIBITS'(NI - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= '1;
      for (int i = 0; i < NI; i++) q_q[i] <= QBITS'(1);
    end else if (cfg_wr && (int'(cfg_idx) < NI)) begin
      q_q[cfg_idx]  <= cfg_quantum;
      en_q[cfg_idx] <= cfg_enable;
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (arb_mode) begin
      if (acc) begin
        cur_d  = pick;
        last_d = pick;
        cnt_d  = q_start;
        if (!beat_eop)           state_d = S_PKT;
        else if (q_start != '0)  state_d = S_TURN;
        else                     state_d = S_ARB;
      end else if (state_q == S_TURN) begin
        state_d = S_ARB;
        cnt_d   = '0;
      end
    end else if (state_q == S_PKT) begin
      if (acc && beat_eop) state_d = (cnt_q == '0) ? S_ARB : S_TURN;
    end else begin
      if (acc) begin
        cnt_d = cnt_q - QBITS'(1);
        if (!beat_eop)               state_d = S_PKT;
        else if (cnt_q == QBITS'(1)) state_d = S_ARB;
        else                         state_d = S_TURN;
      end
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    o_ready = '0;
    o_sel   = reset ? sel : '0;
    o_valid = reset && i_valid[sel];
    o_eop   = reset && i_eop[sel];
    if (reset && i_ready && permit) o_ready[sel] = 1'b1;
  end

endmodule

// File: tb/tb_ct_wrr_sched.sv
// Directed bench for ct_wrr_sched: vector table plus hand sequences for
// quantum turns and asynchronous reset mid-packet.
module tb_ct_wrr_sched;

  logic       clk;
  logic       reset;
  logic [3:0] i_valid;
  logic [3:0] i_eop;
  logic [3:0] o_ready;
  logic       i_ready;
  logic       o_valid;
  logic       o_eop;
  logic [1:0] o_sel;
  logic       cfg_wr;
  logic [1:0] cfg_idx;
  logic [3:0] cfg_quantum;
  logic       cfg_enable;

  int n_cmp = 0;
  int n_bad = 0;

  ct_wrr_sched #(.NI(4), .QBITS(4)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_eop(i_eop), .o_ready(o_ready), .i_ready(i_ready),
    .o_valid(o_valid), .o_eop(o_eop), .o_sel(o_sel),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_quantum(cfg_quantum), .cfg_enable(cfg_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    bit         cw;
    logic [1:0] cidx;
    logic [3:0] cq;
    bit         cen;
    logic [3:0] v;
    logic [3:0] e;
    bit         r;
    logic [1:0] xsel;
    bit         xv;
    bit         xe;
    logic [3:0] xr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit cw, logic [1:0] cidx, logic [3:0] cq, bit cen,
                              logic [3:0] v, logic [3:0] e, bit r,
                              logic [1:0] xsel, bit xv, bit xe, logic [3:0] xr);
    vec_t t;
    t.rst = rst; t.cw = cw; t.cidx = cidx; t.cq = cq; t.cen = cen;
    t.v = v; t.e = e; t.r = r;
    t.xsel = xsel; t.xv = xv; t.xe = xe; t.xr = xr;
    return t;
  endfunction

  task automatic check(input string nm, input int row, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s row=%0d got=%h expected=%h t=%0t", nm, row, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [3:0] e, input bit r);
    i_valid = v;
    i_eop   = e;
    i_ready = r;
  endtask

  task automatic no_cfg();
    cfg_wr = 1'b0; cfg_idx = '0; cfg_quantum = '0; cfg_enable = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(4'h0, 4'h0, 1'b0);
    no_cfg();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [1:0] seq2 [12];
  logic [3:0] bc;
  logic [1:0] es;

  initial begin
    reset = 1'b0;
    no_cfg();
    drive(4'hF, 4'hF, 1'b1);
    #2;
    check("rst_valid", -1, {7'd0, o_valid}, 8'd0);
    check("rst_ready", -1, {4'd0, o_ready}, 8'd0);
    check("rst_eop",   -1, {7'd0, o_eop},   8'd0);
    check("rst_sel",   -1, {6'd0, o_sel},   8'd0);

    // 1-beat packets, q=1: plain round robin
    tbl.push_back(mk(1,0,0,0,0, 4'hF,4'hF,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'hF,4'hF,1, 1,1,1,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'hF,4'hF,1, 2,1,1,4'b0100));
    tbl.push_back(mk(0,0,0,0,0, 4'hF,4'hF,1, 3,1,1,4'b1000));
    tbl.push_back(mk(0,0,0,0,0, 4'hF,4'hF,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'hF,4'hF,1, 1,1,1,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'hF,4'hF,1, 2,1,1,4'b0100));
    tbl.push_back(mk(0,0,0,0,0, 4'hF,4'hF,1, 3,1,1,4'b1000));
    // input 1: 4-beat packet with valid gaps and ready toggling
    tbl.push_back(mk(1,0,0,0,0, 4'b0010,4'b0000,1, 1,1,0,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b1101,4'b1101,1, 1,0,0,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1101,0, 1,1,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1101,1, 1,1,0,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b1101,4'b1101,1, 1,0,0,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1101,1, 1,1,0,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,0, 1,1,1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 1,1,1,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 2,1,1,4'b0100));
    // q[2]=4, input 2 goes idle after one packet: forfeit to 3 with no bubble
    tbl.push_back(mk(1,1,2,4,1, 4'b0000,4'b0000,0, 3,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,0, 4'b0100,4'b0100,1, 2,1,1,4'b0100));
    tbl.push_back(mk(0,0,0,0,0, 4'b1000,4'b1000,1, 3,1,1,4'b1000));
    tbl.push_back(mk(0,0,0,0,0, 4'b0100,4'b0100,1, 2,1,1,4'b0100));
    tbl.push_back(mk(0,0,0,0,0, 4'b0100,4'b0100,1, 2,1,1,4'b0100));
    // disable input 1 mid-packet (q[1]=2): packet finishes, turn forfeited
    tbl.push_back(mk(1,1,1,2,1, 4'b0000,4'b0000,0, 3,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,0, 4'b0010,4'b0000,1, 1,1,0,4'b0010));
    tbl.push_back(mk(0,1,1,2,0, 4'b1111,4'b1101,1, 1,1,0,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 1,1,1,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 2,1,1,4'b0100));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 3,1,1,4'b1000));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 2,1,1,4'b0100));
    tbl.push_back(mk(0,1,1,1,1, 4'b1111,4'b1111,0, 3,1,1,4'b0000));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 3,1,1,4'b1000));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'b1111,4'b1111,1, 1,1,1,4'b0010));
    // quantum 0 behaves as 1
    tbl.push_back(mk(1,1,0,0,1, 4'b0000,4'b0000,0, 3,0,0,4'b0000));
    tbl.push_back(mk(0,0,0,0,0, 4'b0011,4'b0011,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'b0011,4'b0011,1, 1,1,1,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b0011,4'b0011,1, 0,1,1,4'b0001));
    // config write to the input being picked: this turn uses the old q
    tbl.push_back(mk(1,1,0,3,1, 4'b0011,4'b0011,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'b0011,4'b0011,1, 1,1,1,4'b0010));
    tbl.push_back(mk(0,0,0,0,0, 4'b0011,4'b0011,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'b0011,4'b0011,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'b0011,4'b0011,1, 0,1,1,4'b0001));
    tbl.push_back(mk(0,0,0,0,0, 4'b0011,4'b0011,1, 1,1,1,4'b0010));

    foreach (tbl[n]) begin
      if (tbl[n].rst) do_reset();
      else @(negedge clk);
      cfg_wr      = tbl[n].cw;
      cfg_idx     = tbl[n].cidx;
      cfg_quantum = tbl[n].cq;
      cfg_enable  = tbl[n].cen;
      drive(tbl[n].v, tbl[n].e, tbl[n].r);
      #2;
      check("sel",   n, {6'd0, o_sel},   {6'd0, tbl[n].xsel});
      check("valid", n, {7'd0, o_valid}, {7'd0, tbl[n].xv});
      check("eop",   n, {7'd0, o_eop},   {7'd0, tbl[n].xe});
      check("ready", n, {4'd0, o_ready}, {4'd0, tbl[n].xr});
    end

    // q[0]=3, every input sends 2-beat packets: 6 beats from 0, then 2 each from 1,2,3
    seq2 = '{2'd0,2'd0,2'd0,2'd0,2'd0,2'd0,2'd1,2'd1,2'd2,2'd2,2'd3,2'd3};
    do_reset();
    cfg_wr = 1'b1; cfg_idx = 2'd0; cfg_quantum = 4'd3; cfg_enable = 1'b1;
    @(negedge clk);
    no_cfg();
    bc = 4'h0;
    for (int c = 0; c < 24; c++) begin
      es = seq2[c % 12];
      drive(4'hF, bc, 1'b1);
      #2;
      check("wrr_sel",   100 + c, {6'd0, o_sel},   {6'd0, es});
      check("wrr_eop",   100 + c, {7'd0, o_eop},   {7'd0, bc[es]});
      check("wrr_ready", 100 + c, {4'd0, o_ready}, {4'd0, 4'b0001 << es});
      bc[es] = ~bc[es];
      @(negedge clk);
    end

    // async reset asserted while input 2 is mid-packet
    do_reset();
    drive(4'b0100, 4'b0000, 1'b1);
    #2;
    check("pkt_sel", 200, {6'd0, o_sel}, 8'd2);
    @(posedge clk);
    #3;
    drive(4'hF, 4'hF, 1'b1);
    #1;
    check("pkt_sel_hold", 201, {6'd0, o_sel}, 8'd2);
    reset = 1'b0;
    #1;
    check("arst_valid", 202, {7'd0, o_valid}, 8'd0);
    check("arst_ready", 202, {4'd0, o_ready}, 8'd0);
    check("arst_eop",   202, {7'd0, o_eop},   8'd0);
    check("arst_sel",   202, {6'd0, o_sel},   8'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #2;
    check("post_sel",   203, {6'd0, o_sel},   8'd0);
    check("post_ready", 203, {4'd0, o_ready}, 8'b0001);
    @(negedge clk);
    #2;
    check("post_sel2",  204, {6'd0, o_sel},   8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
